// File: rtl/noise_cdf_loader_pkg.sv
// Shared types and sizes for the noise generator CDF loader.
package noise_pkg;
  localparam int CDF_DEPTH  = 128;
  localparam int CDF_W      = 64;
  localparam int LOAD_BEATS = CDF_DEPTH + 1;

  typedef logic [CDF_W-1:0] cdf_t;

  typedef enum logic [2:0] {IDLE, PRIME, BURST, WAIT_DONE, READY, FAULT} loader_state_t;
endpackage

// File: rtl/noise_cdf_loader_if.sv
// ROM read port, generator load port and status bundle of the CDF loader.
interface noise_cdf_loader_if
  import noise_pkg::*;
#(
  parameter int DATA_W = CDF_W,
  parameter int AW     = 7,
  parameter int LW     = 8
);
  logic              start;
  logic              rom_rd_en;
  logic [AW-1:0]     rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              load_mem;
  logic [LW-1:0]     location;
  logic [DATA_W-1:0] mem_data;
  logic              done_wait;
  logic              table_ready;
  logic              busy;
  logic              mono_err;
  logic [AW-1:0]     err_index;
  logic              timeout_err;

  modport master (
    input  start, rom_data, done_wait,
    output rom_rd_en, rom_addr, load_mem, location, mem_data,
           table_ready, busy, mono_err, err_index, timeout_err
  );
  modport slave (
    output start, rom_data, done_wait,
    input  rom_rd_en, rom_addr, load_mem, location, mem_data,
           table_ready, busy, mono_err, err_index, timeout_err
  );
endinterface

// File: rtl/noise_cdf_loader_mono.sv
// Registered monotonicity checker; latches the index of the first decreasing entry.
module cdf_mono_check #(
  parameter int DATA_W = 64,
  parameter int AW     = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              first,
  input  logic [AW-1:0]     idx,
  input  logic [DATA_W-1:0] data,
  output logic              mono_err,
  output logic [AW-1:0]     err_index
);
  logic [DATA_W-1:0] prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev      <= '0;
      mono_err  <= 1'b0;
      err_index <= '0;
    end else if (en) begin
      prev <= data;
      // equal neighbours are a legal zero-probability bin
      if (!first && !mono_err && (data < prev)) begin
        mono_err  <= 1'b1;
        err_index <= idx;
      end
    end
  end
endmodule

// File: rtl/noise_cdf_loader.sv
// Loads the CDF table from ROM into the noise generator as one burst, then waits for done_wait.
module noise_cdf_loader
  import noise_pkg::*;
#(
  parameter int DEPTH        = CDF_DEPTH,
  parameter int DATA_W       = CDF_W,
  parameter int ROM_LAT      = 1,
  parameter int DONE_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  noise_cdf_loader_if.master  bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int BEATS = DEPTH + 1;
  localparam int BW    = $clog2(BEATS + 1);
  localparam int PW    = $clog2(ROM_LAT + 1);
  localparam int CW    = $clog2(DONE_TIMEOUT + 1);

  loader_state_t state;
  logic [LW-1:0] addr_cnt;
  logic [BW-1:0] beat;
  logic [PW-1:0] prime_cnt;
  logic [CW-1:0] wait_cnt;
  logic          mono_en, mono_first, mono_err_q;
  logic [AW-1:0] mono_idx, err_index_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      addr_cnt        <= '0;
      beat            <= '0;
      prime_cnt       <= '0;
      wait_cnt        <= '0;
      bus.rom_rd_en   <= 1'b0;
      bus.rom_addr    <= '0;
      bus.load_mem    <= 1'b0;
      bus.location    <= '0;
      bus.mem_data    <= '0;
      bus.table_ready <= 1'b0;
      bus.busy        <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      // address n is issued n cycles after start, independent of ROM latency
      bus.rom_rd_en <= 1'b0;
      if ((state == PRIME || state == BURST) && addr_cnt < LW'(DEPTH)) begin
        bus.rom_rd_en <= 1'b1;
        bus.rom_addr  <= AW'(addr_cnt);
        addr_cnt      <= addr_cnt + 1'b1;
      end
      case (state)
        IDLE: if (bus.start) begin
          state         <= PRIME;
          bus.busy      <= 1'b1;
          bus.rom_rd_en <= 1'b1;
          bus.rom_addr  <= '0;
          addr_cnt      <= LW'(1);
          prime_cnt     <= '0;
        end
        PRIME: begin
          prime_cnt <= prime_cnt + 1'b1;
          if (prime_cnt == PW'(ROM_LAT - 1)) begin
            state        <= BURST;
            bus.load_mem <= 1'b1;
            bus.location <= '0;
            bus.mem_data <= '0;
            beat         <= BW'(1);
          end
        end
        BURST: if (beat == BW'(BEATS)) begin
          state        <= WAIT_DONE;
          bus.load_mem <= 1'b0;
          bus.location <= '0;
          bus.mem_data <= '0;
          wait_cnt     <= '0;
        end else begin
          bus.location <= LW'(beat);
          bus.mem_data <= bus.rom_data;
          beat         <= beat + 1'b1;
        end
        WAIT_DONE: if (bus.done_wait) begin
          state           <= READY;
          bus.busy        <= 1'b0;
          bus.table_ready <= 1'b1;
        end else if (wait_cnt == CW'(DONE_TIMEOUT - 1)) begin
          state           <= FAULT;
          bus.busy        <= 1'b0;
          bus.timeout_err <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // beat b forwards ROM[b-1]; the first forwarded entry only seeds the comparator
  assign mono_en    = (state == BURST) && (beat != BW'(BEATS));
  assign mono_first = (beat == BW'(1));
  assign mono_idx   = AW'(beat - 1'b1);

  cdf_mono_check #(.DATA_W(DATA_W), .AW(AW)) u_mono (
    .clk       (clk),
    .rst       (rst),
    .en        (mono_en),
    .first     (mono_first),
    .idx       (mono_idx),
    .data      (bus.rom_data),
    .mono_err  (mono_err_q),
    .err_index (err_index_q)
  );

  assign bus.mono_err  = mono_err_q;
  assign bus.err_index = err_index_q;
endmodule

// File: tb/tb_noise_cdf_loader.sv
// Directed bench: two loaders (ROM latency 1 and 2) fed by behavioural ROMs.
module tb_noise_cdf_loader;
  import noise_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic done_wait = 1'b0;
  logic sel = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  noise_cdf_loader_if ia();
  noise_cdf_loader_if ib();

  noise_cdf_loader #(.ROM_LAT(1)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  noise_cdf_loader #(.ROM_LAT(2)) dut_b (.clk(clk), .rst(rst), .bus(ib));

  cdf_t rom [CDF_DEPTH];
  cdf_t qa, sb1, qb;

  always @(posedge clk) if (ia.rom_rd_en) qa <= rom[ia.rom_addr];
  always @(posedge clk) begin
    if (ib.rom_rd_en) sb1 <= rom[ib.rom_addr];
    qb <= sb1;
  end

  assign ia.rom_data  = qa;
  assign ib.rom_data  = qb;
  assign ia.start     = start & ~sel;
  assign ib.start     = start & sel;
  assign ia.done_wait = done_wait;
  assign ib.done_wait = done_wait;

  logic       m_load_mem, m_rom_rd_en, m_table_ready, m_busy, m_mono_err, m_timeout_err;
  logic [7:0] m_location;
  logic [6:0] m_rom_addr, m_err_index;
  cdf_t       m_mem_data;

  assign m_load_mem    = sel ? ib.load_mem    : ia.load_mem;
  assign m_rom_rd_en   = sel ? ib.rom_rd_en   : ia.rom_rd_en;
  assign m_rom_addr    = sel ? ib.rom_addr    : ia.rom_addr;
  assign m_location    = sel ? ib.location    : ia.location;
  assign m_mem_data    = sel ? ib.mem_data    : ia.mem_data;
  assign m_table_ready = sel ? ib.table_ready : ia.table_ready;
  assign m_busy        = sel ? ib.busy        : ia.busy;
  assign m_mono_err    = sel ? ib.mono_err    : ia.mono_err;
  assign m_err_index   = sel ? ib.err_index   : ia.err_index;
  assign m_timeout_err = sel ? ib.timeout_err : ia.timeout_err;

  int   first_load, load_cnt, beat_bad, rd_cnt, addr_bad, ready_at, timeout_at;
  cdf_t mem_b1, mem_b128;
  logic busy_c1;

  task automatic fill_rom();
    for (int k = 0; k < CDF_DEPTH; k++) rom[k] = cdf_t'(k) << 49;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; done_wait = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Start pulse at cycle 0, then observe the selected loader for `cycles` cycles.
  task automatic run_burst(input int cycles, input int done_at, input int s1, input int s2);
    cdf_t exp;
    first_load = -1; load_cnt = 0; beat_bad = 0; rd_cnt = 0; addr_bad = 0;
    ready_at = -1; timeout_at = -1; mem_b1 = '1; mem_b128 = '1; busy_c1 = 1'b0;
    @(negedge clk);
    start = 1'b1;
    done_wait = (done_at == 0);
    for (int cyc = 1; cyc <= cycles; cyc++) begin
      @(negedge clk);
      start = (cyc == s1) || (cyc == s2);
      done_wait = (done_at >= 0) && (cyc >= done_at);
      if (cyc == 1) busy_c1 = m_busy;
      if (m_load_mem) begin
        if (first_load < 0) first_load = cyc;
        if (load_cnt <= CDF_DEPTH) begin
          exp = (load_cnt == 0) ? '0 : rom[load_cnt-1];
          if (m_location !== 8'(load_cnt) || m_mem_data !== exp) beat_bad++;
        end
        if (load_cnt == 1) mem_b1 = m_mem_data;
        if (load_cnt == 128) mem_b128 = m_mem_data;
        load_cnt++;
      end
      if (m_rom_rd_en) begin
        if (m_rom_addr !== 7'(rd_cnt)) addr_bad++;
        rd_cnt++;
      end
      if (m_table_ready && ready_at < 0) ready_at = cyc;
      if (m_timeout_err && timeout_at < 0) timeout_at = cyc;
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    do_reset();
    n_vec++; if (ia.load_mem !== 1'b0) begin n_bad++; $display("FAIL rst_a_load_mem got %b want 0", ia.load_mem); end
    n_vec++; if (ia.rom_rd_en !== 1'b0) begin n_bad++; $display("FAIL rst_a_rom_rd_en got %b want 0", ia.rom_rd_en); end
    n_vec++; if (ia.busy !== 1'b0) begin n_bad++; $display("FAIL rst_a_busy got %b want 0", ia.busy); end
    n_vec++; if (ia.table_ready !== 1'b0) begin n_bad++; $display("FAIL rst_a_table_ready got %b want 0", ia.table_ready); end
    n_vec++; if ({ia.mono_err, ia.err_index, ia.timeout_err} !== 9'd0) begin n_bad++; $display("FAIL rst_a_errs got %h want 0", {ia.mono_err, ia.err_index, ia.timeout_err}); end
    n_vec++; if ({ia.location, ia.mem_data, ia.rom_addr} !== 79'd0) begin n_bad++; $display("FAIL rst_a_data got %h want 0", {ia.location, ia.mem_data, ia.rom_addr}); end
    n_vec++; if ({ib.load_mem, ib.busy, ib.table_ready, ib.rom_rd_en} !== 4'd0) begin n_bad++; $display("FAIL rst_b_ctrl got %b want 0", {ib.load_mem, ib.busy, ib.table_ready, ib.rom_rd_en}); end
  endtask

  task automatic test_load_l1();
    sel = 1'b0; fill_rom(); do_reset();
    run_burst(140, 132, -1, -1);
    n_vec++; if (busy_c1 !== 1'b1) begin n_bad++; $display("FAIL l1_busy_prime got %b want 1", busy_c1); end
    n_vec++; if (first_load !== 2) begin n_bad++; $display("FAIL l1_first_load got %0d want 2", first_load); end
    n_vec++; if (load_cnt !== 129) begin n_bad++; $display("FAIL l1_beats got %0d want 129", load_cnt); end
    n_vec++; if (beat_bad !== 0) begin n_bad++; $display("FAIL l1_beat_data got %0d bad beats want 0", beat_bad); end
    n_vec++; if (mem_b1 !== 64'd0) begin n_bad++; $display("FAIL l1_beat1 got %h want 0", mem_b1); end
    n_vec++; if (mem_b128 !== (64'd127 << 49)) begin n_bad++; $display("FAIL l1_beat128 got %h want %h", mem_b128, 64'd127 << 49); end
    n_vec++; if (rd_cnt !== 128 || addr_bad !== 0) begin n_bad++; $display("FAIL l1_rom_reads got %0d/%0d want 128/0", rd_cnt, addr_bad); end
    n_vec++; if (ready_at !== 133) begin n_bad++; $display("FAIL l1_ready_cycle got %0d want 133", ready_at); end
    n_vec++; if (m_mono_err !== 1'b0 || m_timeout_err !== 1'b0) begin n_bad++; $display("FAIL l1_errs got %b%b want 00", m_mono_err, m_timeout_err); end
    n_vec++; if (m_busy !== 1'b0 || m_load_mem !== 1'b0) begin n_bad++; $display("FAIL l1_idle_out got %b%b want 00", m_busy, m_load_mem); end
  endtask

  task automatic test_done_early();
    sel = 1'b0; fill_rom(); do_reset();
    run_burst(140, 1, -1, -1);
    n_vec++; if (load_cnt !== 129) begin n_bad++; $display("FAIL early_beats got %0d want 129", load_cnt); end
    n_vec++; if (ready_at !== 132) begin n_bad++; $display("FAIL early_ready_cycle got %0d want 132", ready_at); end
  endtask

  task automatic test_mono();
    sel = 1'b0; fill_rom();
    rom[40] = rom[39] - 64'd1;
    rom[90] = rom[89] - 64'd5;
    rom[100] = rom[99];
    do_reset();
    run_burst(140, 132, -1, -1);
    n_vec++; if (m_mono_err !== 1'b1) begin n_bad++; $display("FAIL mono_err got %b want 1", m_mono_err); end
    n_vec++; if (m_err_index !== 7'd40) begin n_bad++; $display("FAIL mono_index got %0d want 40", m_err_index); end
    n_vec++; if (load_cnt !== 129 || beat_bad !== 0) begin n_bad++; $display("FAIL mono_burst got %0d/%0d want 129/0", load_cnt, beat_bad); end
    n_vec++; if (m_table_ready !== 1'b1) begin n_bad++; $display("FAIL mono_ready got %b want 1", m_table_ready); end
  endtask

  task automatic test_timeout();
    sel = 1'b0; fill_rom(); do_reset();
    run_burst(160, -1, -1, -1);
    n_vec++; if (timeout_at !== 147) begin n_bad++; $display("FAIL to_cycle got %0d want 147", timeout_at); end
    n_vec++; if (m_table_ready !== 1'b0 || m_busy !== 1'b0) begin n_bad++; $display("FAIL to_fault_out got %b%b want 00", m_table_ready, m_busy); end
    run_burst(150, -1, -1, -1);
    n_vec++; if (load_cnt !== 0 || rd_cnt !== 0) begin n_bad++; $display("FAIL to_restart got %0d/%0d want 0/0", load_cnt, rd_cnt); end
    n_vec++; if (m_timeout_err !== 1'b1 || m_busy !== 1'b0) begin n_bad++; $display("FAIL to_hold got %b%b want 10", m_timeout_err, m_busy); end
  endtask

  task automatic test_reset_mid();
    bit hit;
    sel = 1'b0; fill_rom(); do_reset();
    hit = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 1; cyc <= 200 && !hit; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (m_load_mem && m_location == 8'd60) begin rst = 1'b1; hit = 1'b1; end
    end
    n_vec++; if (!hit) begin n_bad++; $display("FAIL rmid_beat60 got none want beat 60 within 200 cycles"); end
    @(negedge clk);
    n_vec++; if ({m_load_mem, m_rom_rd_en, m_busy, m_table_ready} !== 4'd0) begin n_bad++; $display("FAIL rmid_ctrl got %b want 0000", {m_load_mem, m_rom_rd_en, m_busy, m_table_ready}); end
    n_vec++; if ({m_location, m_mem_data} !== 72'd0) begin n_bad++; $display("FAIL rmid_data got %h want 0", {m_location, m_mem_data}); end
    rst = 1'b0;
    run_burst(140, 132, -1, -1);
    n_vec++; if (first_load !== 2 || load_cnt !== 129 || beat_bad !== 0) begin n_bad++; $display("FAIL rmid_reload got %0d/%0d/%0d want 2/129/0", first_load, load_cnt, beat_bad); end
    n_vec++; if (ready_at !== 133) begin n_bad++; $display("FAIL rmid_ready got %0d want 133", ready_at); end
  endtask

  task automatic test_lat2();
    sel = 1'b1; fill_rom(); do_reset();
    run_burst(145, 133, -1, -1);
    n_vec++; if (first_load !== 3) begin n_bad++; $display("FAIL l2_first_load got %0d want 3", first_load); end
    n_vec++; if (load_cnt !== 129 || beat_bad !== 0) begin n_bad++; $display("FAIL l2_burst got %0d/%0d want 129/0", load_cnt, beat_bad); end
    n_vec++; if (mem_b128 !== (64'd127 << 49)) begin n_bad++; $display("FAIL l2_beat128 got %h want %h", mem_b128, 64'd127 << 49); end
    n_vec++; if (rd_cnt !== 128 || addr_bad !== 0) begin n_bad++; $display("FAIL l2_rom_reads got %0d/%0d want 128/0", rd_cnt, addr_bad); end
    n_vec++; if (ready_at !== 134) begin n_bad++; $display("FAIL l2_ready_cycle got %0d want 134", ready_at); end
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    sel = 1'b0; fill_rom(); do_reset();
    run_burst(160, 132, 50, 140);
    n_vec++; if (load_cnt !== 129 || beat_bad !== 0) begin n_bad++; $display("FAIL b2b_burst got %0d/%0d want 129/0", load_cnt, beat_bad); end
    n_vec++; if (rd_cnt !== 128) begin n_bad++; $display("FAIL b2b_rom_reads got %0d want 128", rd_cnt); end
    n_vec++; if (ready_at !== 133 || m_table_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready got %0d/%b want 133/1", ready_at, m_table_ready); end
  endtask

  initial begin
    test_reset();
    test_load_l1();
    test_done_early();
    test_mono();
    test_timeout();
    test_reset_mid();
    test_lat2();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/noise_cdf_loader.md
Name: noise_cdf_loader

Overview:
- Upstream configuration stage for the 128-bin noise generator.
- After start, reads the 128-entry 64-bit cumulative-probability table from a synchronous ROM.
- Streams the table to the generator's load port (load_mem/location/mem_data) as one 129-beat burst, with location leading data by one beat, then waits for the generator's done_wait.
- Raises table_ready to release the noise path. Checks the table is monotonic non-decreasing and flags a done_wait timeout.

Parameters:
DEPTH, 128, number of CDF entries (bins)
DATA_W, 64, CDF entry width
ROM_LAT, 1, ROM read latency in cycles (1 or 2)
DONE_TIMEOUT, 16, cycles allowed between end of burst and done_wait before fault

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse; begins a table load
rom_rd_en  out  1  ROM read strobe
rom_addr  out  7  ROM entry address
rom_data  in  DATA_W  ROM read data, valid ROM_LAT cycles after rom_rd_en
load_mem  out  1  burst-active strobe to generator
location  out  8  table index to generator (leads data by one beat)
mem_data  out  DATA_W  CDF value to generator
done_wait  in  1  generator table-loaded flag (level, sticky)
table_ready  out  1  table loaded and verified path released
busy  out  1  high in any state other than IDLE/READY/FAULT
mono_err  out  1  sticky: some ROM[k] < ROM[k-1]
err_index  out  7  first k at which mono_err was detected
timeout_err  out  1  sticky: done_wait not seen within DONE_TIMEOUT

Behaviour:
- All outputs registered.
- On rst, every output is 0 and the state is IDLE. Reset mid-burst aborts immediately: load_mem=0 on the next cycle and no further ROM reads are issued.

States:
- IDLE: start → PRIME.
- PRIME: issue ROM reads for addresses 0..ROM_LAT-1. Stay exactly ROM_LAT cycles → BURST.
- BURST: 129 beats, b = 0..128.
  - load_mem=1 and location=b on every beat.
  - mem_data=0 at b=0; mem_data=ROM[b-1] for b≥1.
  - ROM reads are pipelined so that rom_data for beat b arrives on time. Address issue stops after address 127, so rom_addr never exceeds 127.
  - After beat 128 → WAIT_DONE.
- WAIT_DONE:
  - load_mem=0, location=0, mem_data=0.
  - A counter starts at 0. When done_wait=1 → READY.
  - When the counter reaches DONE_TIMEOUT-1 with done_wait still 0 → FAULT and set timeout_err.
- READY: table_ready=1. Held until rst.
- FAULT: table_ready=0. Held until rst.
- start is ignored outside IDLE. The generator accepts one load per reset, so no reload path exists.

Monotonicity check:
- Compare each ROM[k] with ROM[k-1] as data is forwarded, for k = 1..127, as unsigned DATA_W values.
- On the first violation, set mono_err and latch err_index=k. Later violations do not change err_index.
- A monotonicity error does not stop the burst; READY is still reached. mono_err qualifies table_ready at system level.
- Equal adjacent entries are legal (zero-probability bin).

Boundary and timing rules:
- done_wait already high when WAIT_DONE is entered → READY on the next cycle.
- done_wait high during BURST is ignored.
- busy=1 in PRIME, BURST and WAIT_DONE.
- Latency from start to first load_mem=1 is ROM_LAT+1 cycles.
- Latency from start to the earliest table_ready is ROM_LAT+131 cycles.

Decomposition:
- Package noise_pkg holds:
  - CDF_DEPTH=128, CDF_W=64, LOAD_BEATS=CDF_DEPTH+1;
  - typedef cdf_t (logic [CDF_W-1:0]);
  - enum loader_state_t {IDLE, PRIME, BURST, WAIT_DONE, READY, FAULT}.
- Single module. Optional sub-module cdf_mono_check, the registered comparator that produces the first-error latch.

Test Plan:
- ROM[k]=k·2^56/128 (monotonic), ROM_LAT=1, done_wait rises 1 cycle after beat 128 → exactly 129 load_mem cycles; beat b=1 has mem_data=0 and beat b=128 has mem_data=127·2^49; table_ready at cycle start+133; mono_err=0.
- ROM[40]=ROM[39]-1 and ROM[90]<ROM[89] → mono_err=1, err_index=40 (not 90), burst completes, table_ready=1.
- done_wait held 0 → timeout_err=1 exactly DONE_TIMEOUT cycles after WAIT_DONE entry; FAULT held; second start ignored.
- rst asserted at beat 60 → load_mem=0 and all outputs 0 next cycle; a new start reloads from b=0.
- ROM_LAT=2 → first load_mem 3 cycles after start; same data alignment as the first scenario; rom_addr max 127.
- start pulsed during BURST and in READY → no restart, beat count stays 129.
